// File: rtl/mesi_pkg.sv
// Shared types for the MESI snoop controller: line states, response codes,
// controller FSM states and index/tag width helpers.
package mesi_pkg;

  typedef enum logic [1:0] {
    LS_I = 2'b00,
    LS_S = 2'b01,
    LS_E = 2'b10,
    LS_M = 2'b11
  } line_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;  // final line state S
  localparam logic [1:0] RESP_EXOKAY = 2'b01;  // final line state E or M

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_VICTIM_WB,
    ST_SNOOP,
    ST_PEER_WB,
    ST_FILL,
    ST_RESP
  } fsm_state_e;

  localparam int unsigned DEF_ADDR_W = 20;
  localparam int unsigned DEF_SETS   = 16;

  // SETS is a power of two >= 2; index = low bits, tag = the rest.
  function automatic int unsigned idx_width(input int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned tag_width(input int unsigned addr_w, input int unsigned sets);
    return addr_w - idx_width(sets);
  endfunction

endpackage

// File: rtl/mesi_rr_arbiter.sv
// Round-robin arbiter. The served requester becomes lowest priority.
//   req_i     : request vector
//   advance_i : move the pointer past served_i
//   served_i  : index of the requester just served
//   grant_o   : highest-priority active requester (don't-care if none)
module mesi_rr_arbiter #(
  parameter int unsigned N = 2,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req_i,
  input  logic          advance_i,
  input  logic [IW-1:0] served_i,
  output logic [IW-1:0] grant_o
);

  logic [IW-1:0] ptr_q;
  logic          found;
  int unsigned   cand;

  always_comb begin
    grant_o = ptr_q;
    found   = 1'b0;
    cand    = 0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = (32'(ptr_q) + k) % N;
      if (!found && req_i[cand]) begin
        grant_o = IW'(cand);
        found   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (advance_i) begin
      ptr_q <= (served_i == IW'(N - 1)) ? '0 : served_i + 1'b1;
    end
  end

endmodule

// File: rtl/mesi_snoop_ctrl.sv
// MESI snoop controller for N_CORE private direct-mapped one-word caches.
// One request at a time is admitted through a round-robin arbiter, looked up,
// snooped against peer caches, and completed with victim/peer writebacks and
// fills on a single shared memory port.
//   req_*  : per-core request channel (valid/ready, packed payload)
//   rsp_*  : one-cycle response pulse to the served core
//   mem_*  : registered memory request held until mem_ack
module mesi_snoop_ctrl
  import mesi_pkg::*;
#(
  parameter int unsigned N_CORE = 2,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SETS   = DEF_SETS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CORE-1:0]        req_valid,
  output logic [N_CORE-1:0]        req_ready,
  input  logic [N_CORE-1:0]        req_we,
  input  logic [N_CORE*ADDR_W-1:0] req_addr,
  input  logic [N_CORE*DATA_W-1:0] req_wdata,
  output logic [N_CORE-1:0]        rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_hit,
  output logic [1:0]               rsp_resp,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic                     mem_ack,
  input  logic [DATA_W-1:0]        mem_rdata
);

  localparam int unsigned IDX_W = idx_width(SETS);
  localparam int unsigned TAG_W = tag_width(ADDR_W, SETS);
  localparam int unsigned GW    = (N_CORE > 1) ? $clog2(N_CORE) : 1;

  fsm_state_e        state_q;
  logic [GW-1:0]     g_q, peer_q, gnt, peer_idx;
  logic              we_q, hit_q, peer_v_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  line_state_e       lst_q [N_CORE][SETS];
  logic [TAG_W-1:0]  tag_q [N_CORE][SETS];
  logic [DATA_W-1:0] dat_q [N_CORE][SETS];

  logic [N_CORE-1:0] rsp_valid_q;
  logic              rsp_hit_q, mem_req_q, mem_we_q;
  logic [1:0]        rsp_resp_q;
  logic [DATA_W-1:0] rsp_rdata_q, mem_wdata_q;
  logic [ADDR_W-1:0] mem_addr_q;

  logic              xfer, own_hit, peer_any, peer_m, mem_done;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag, own_tag;
  line_state_e       own_st;
  logic [DATA_W-1:0] own_dat;
  logic [N_CORE-1:0] peer_match;

  mesi_rr_arbiter #(.N(N_CORE)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_valid),
    .advance_i (state_q == ST_RESP),
    .served_i  (g_q),
    .grant_o   (gnt)
  );

  assign xfer     = !rst && (state_q == ST_IDLE) && req_valid[gnt];
  assign idx      = addr_q[IDX_W-1:0];
  assign tag      = addr_q[ADDR_W-1:IDX_W];
  assign own_st   = lst_q[g_q][idx];
  assign own_tag  = tag_q[g_q][idx];
  assign own_dat  = dat_q[g_q][idx];
  assign own_hit  = (own_st != LS_I) && (own_tag == tag);
  assign mem_done = mem_req_q && mem_ack;

  always_comb begin
    req_ready      = '0;
    req_ready[gnt] = xfer;
  end

  // Peers holding the requested line; at most one can be in M.
  always_comb begin
    peer_match = '0;
    peer_m     = 1'b0;
    peer_idx   = '0;
    for (int unsigned p = 0; p < N_CORE; p++) begin
      if (p != 32'(g_q) && lst_q[p][idx] != LS_I && tag_q[p][idx] == tag) begin
        peer_match[p] = 1'b1;
        if (lst_q[p][idx] == LS_M) begin
          peer_m   = 1'b1;
          peer_idx = GW'(p);
        end
      end
    end
    peer_any = |peer_match;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      g_q         <= '0;
      peer_q      <= '0;
      we_q        <= 1'b0;
      hit_q       <= 1'b0;
      peer_v_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= '0;
      rsp_hit_q   <= 1'b0;
      rsp_resp_q  <= '0;
      rsp_rdata_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      for (int unsigned c = 0; c < N_CORE; c++) begin
        for (int unsigned s = 0; s < SETS; s++) begin
          lst_q[c][s] <= LS_I;
          tag_q[c][s] <= '0;
          dat_q[c][s] <= '0;
        end
      end
    end else begin
      rsp_valid_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (xfer) begin
            g_q     <= gnt;
            we_q    <= req_we[gnt];
            addr_q  <= req_addr[32'(gnt)*ADDR_W +: ADDR_W];
            wdata_q <= req_wdata[32'(gnt)*DATA_W +: DATA_W];
            state_q <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          hit_q <= own_hit;
          if (own_hit && !we_q) begin
            rsp_valid_q[g_q] <= 1'b1;
            rsp_hit_q        <= 1'b1;
            rsp_resp_q       <= (own_st == LS_S) ? RESP_OKAY : RESP_EXOKAY;
            rsp_rdata_q      <= own_dat;
            state_q          <= ST_RESP;
          end else if (own_hit && own_st != LS_S) begin
            dat_q[g_q][idx]  <= wdata_q;
            lst_q[g_q][idx]  <= LS_M;
            rsp_valid_q[g_q] <= 1'b1;
            rsp_hit_q        <= 1'b1;
            rsp_resp_q       <= RESP_EXOKAY;
            state_q          <= ST_RESP;
          end else if (!own_hit && own_st == LS_M) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= {own_tag, idx};
            mem_wdata_q <= own_dat;
            state_q     <= ST_VICTIM_WB;
          end else begin
            state_q <= ST_SNOOP;
          end
        end
        ST_VICTIM_WB: begin
          if (mem_done) begin
            mem_req_q       <= 1'b0;
            mem_we_q        <= 1'b0;
            lst_q[g_q][idx] <= LS_I;
            state_q         <= ST_SNOOP;
          end
        end
        ST_SNOOP: begin
          if (peer_m) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= addr_q;
            mem_wdata_q <= dat_q[peer_idx][idx];
            peer_q      <= peer_idx;
            state_q     <= ST_PEER_WB;
          end else if (we_q) begin
            // Write-allocate: no memory read, peers invalidated.
            for (int unsigned p = 0; p < N_CORE; p++) begin
              if (peer_match[p]) lst_q[p][idx] <= LS_I;
            end
            tag_q[g_q][idx]  <= tag;
            dat_q[g_q][idx]  <= wdata_q;
            lst_q[g_q][idx]  <= LS_M;
            rsp_valid_q[g_q] <= 1'b1;
            rsp_hit_q        <= hit_q;
            rsp_resp_q       <= RESP_EXOKAY;
            state_q          <= ST_RESP;
          end else begin
            for (int unsigned p = 0; p < N_CORE; p++) begin
              if (peer_match[p]) lst_q[p][idx] <= LS_S;
            end
            peer_v_q   <= peer_any;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= addr_q;
            state_q    <= ST_FILL;
          end
        end
        ST_PEER_WB: begin
          if (mem_done) begin
            mem_req_q        <= 1'b0;
            mem_we_q         <= 1'b0;
            tag_q[g_q][idx]  <= tag;
            rsp_valid_q[g_q] <= 1'b1;
            rsp_hit_q        <= hit_q;
            state_q          <= ST_RESP;
            if (we_q) begin
              lst_q[peer_q][idx] <= LS_I;
              dat_q[g_q][idx]    <= wdata_q;
              lst_q[g_q][idx]    <= LS_M;
              rsp_resp_q         <= RESP_EXOKAY;
            end else begin
              lst_q[peer_q][idx] <= LS_S;
              dat_q[g_q][idx]    <= dat_q[peer_q][idx];
              lst_q[g_q][idx]    <= LS_S;
              rsp_resp_q         <= RESP_OKAY;
              rsp_rdata_q        <= dat_q[peer_q][idx];
            end
          end
        end
        ST_FILL: begin
          if (mem_done) begin
            mem_req_q        <= 1'b0;
            tag_q[g_q][idx]  <= tag;
            dat_q[g_q][idx]  <= mem_rdata;
            lst_q[g_q][idx]  <= peer_v_q ? LS_S : LS_E;
            rsp_valid_q[g_q] <= 1'b1;
            rsp_hit_q        <= hit_q;
            rsp_resp_q       <= peer_v_q ? RESP_OKAY : RESP_EXOKAY;
            rsp_rdata_q      <= mem_rdata;
            state_q          <= ST_RESP;
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_hit   = rsp_hit_q;
  assign rsp_resp  = rsp_resp_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mesi_snoop_ctrl.sv
// Bench for mesi_snoop_ctrl (2 cores, 20-bit addresses, 16 sets): directed
// scenarios followed by random traffic, checked against a transaction-level
// MESI model of the caches.
module tb_mesi_snoop_ctrl;

  localparam int LI = 0, LS = 1, LE = 2, LM = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, req_we, rsp_valid;
  logic [39:0] req_addr;
  logic [63:0] req_wdata;
  logic [31:0] rsp_rdata, mem_wdata, mem_rdata;
  logic        rsp_hit, mem_req, mem_we, mem_ack;
  logic [1:0]  rsp_resp;
  logic [19:0] mem_addr;

  mesi_snoop_ctrl #(.N_CORE(2), .ADDR_W(20), .DATA_W(32), .SETS(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_hit(rsp_hit), .rsp_resp(rsp_resp),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct { bit we; logic [19:0] addr; logic [31:0] data; } memop_t;

  int          mst  [2][16];
  int unsigned mtag [2][16];
  logic [31:0] mdat [2][16];
  int          mptr;
  memop_t      exp_ops[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] oh(input int c);
    return 2'(1 << c);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++)
      for (int s = 0; s < 16; s++) begin
        mst[c][s] = LI; mtag[c][s] = 0; mdat[c][s] = '0;
      end
    mptr = 0;
  endtask

  // Applies one request to the model; returns the expected response and
  // leaves the expected memory traffic in exp_ops.
  task automatic model(input int c, input bit we, input logic [19:0] a,
                       input logic [31:0] wd, input logic [31:0] fd,
                       output bit ehit, output logic [1:0] eresp,
                       output logic [31:0] erd, output int elat);
    int ix, pm;
    int unsigned tg;
    bit anyv;
    memop_t op;
    ix = int'(a % 20'd16);
    tg = int'(a / 20'd16);
    pm = -1; anyv = 0; erd = '0; elat = 0; eresp = 2'b00;
    exp_ops.delete();
    ehit = (mst[c][ix] != LI) && (mtag[c][ix] == tg);
    if (ehit && !we) begin
      erd = mdat[c][ix]; eresp = (mst[c][ix] == LS) ? 2'b00 : 2'b01; elat = 2;
    end else if (ehit && mst[c][ix] != LS) begin
      mdat[c][ix] = wd; mst[c][ix] = LM; eresp = 2'b01; elat = 2;
    end else begin
      if (!ehit && mst[c][ix] == LM) begin
        op.we = 1; op.addr = 20'(mtag[c][ix] * 16 + ix); op.data = mdat[c][ix];
        exp_ops.push_back(op);
        mst[c][ix] = LI;
      end
      for (int p = 0; p < 2; p++)
        if (p != c && mst[p][ix] != LI && mtag[p][ix] == tg) begin
          anyv = 1;
          if (mst[p][ix] == LM) pm = p;
        end
      mtag[c][ix] = tg;
      if (pm >= 0) begin
        op.we = 1; op.addr = a; op.data = mdat[pm][ix];
        exp_ops.push_back(op);
        if (we) begin
          mst[pm][ix] = LI; mst[c][ix] = LM; mdat[c][ix] = wd; eresp = 2'b01;
        end else begin
          mst[pm][ix] = LS; mst[c][ix] = LS; mdat[c][ix] = mdat[pm][ix];
          erd = mdat[pm][ix]; eresp = 2'b00;
        end
      end else if (we) begin
        for (int p = 0; p < 2; p++)
          if (p != c && mst[p][ix] != LI && mtag[p][ix] == tg) mst[p][ix] = LI;
        mst[c][ix] = LM; mdat[c][ix] = wd; eresp = 2'b01;
      end else begin
        for (int p = 0; p < 2; p++)
          if (p != c && mst[p][ix] != LI && mtag[p][ix] == tg) mst[p][ix] = LS;
        op.we = 0; op.addr = a; op.data = '0;
        exp_ops.push_back(op);
        mst[c][ix] = anyv ? LS : LE; mdat[c][ix] = fd; erd = fd;
        eresp = anyv ? 2'b00 : 2'b01;
      end
      if (exp_ops.size() == 0) elat = 3;
    end
  endtask

  task automatic do_txn(input int c, input bit we, input logic [19:0] a,
                        input logic [31:0] wd, input logic [31:0] fd, input int dly);
    bit ehit, done, in_op, ack_on;
    logic [1:0] eresp;
    logic [31:0] erd;
    int elat, k, n, cnt;
    memop_t cur;
    model(c, we, a, wd, fd, ehit, eresp, erd, elat);
    @(negedge clk);
    req_valid[c] = 1'b1; req_we[c] = we;
    req_addr[c*20 +: 20] = a; req_wdata[c*32 +: 32] = wd;
    #1; n = 0;
    while (!req_ready[c] && n < 50) begin @(negedge clk); #1; n++; end
    check("accept", 32'(n < 50), 1);
    @(posedge clk); #1; req_valid[c] = 1'b0;
    k = 0; done = 0; in_op = 0; ack_on = 0; cnt = 0;
    cur.we = 0; cur.addr = '0; cur.data = '0;
    while (!done && k < 200) begin
      @(negedge clk); k++;
      if (ack_on) begin mem_ack = 1'b0; ack_on = 0; in_op = 0; end
      if (mem_req && !in_op) begin
        check("mem_op_expected", 32'(exp_ops.size() != 0), 1);
        if (exp_ops.size() != 0) cur = exp_ops.pop_front();
        else begin cur.we = mem_we; cur.addr = mem_addr; cur.data = mem_wdata; end
        in_op = 1; cnt = dly;
      end
      if (in_op && !ack_on) begin
        check("mem_req_held", 32'(mem_req), 1);
        check("mem_we", 32'(mem_we), 32'(cur.we));
        check("mem_addr", 32'(mem_addr), 32'(cur.addr));
        if (cur.we) check("mem_wdata", mem_wdata, cur.data);
        if (cnt == 0) begin
          mem_ack = 1'b1; mem_rdata = cur.we ? $urandom : fd; ack_on = 1;
        end else cnt--;
      end
      if (rsp_valid != 2'b00) done = 1;
    end
    if (ack_on) mem_ack = 1'b0;
    check("rsp_seen", 32'(done), 1);
    check("rsp_core", 32'(rsp_valid), 32'(oh(c)));
    check("rsp_hit", 32'(rsp_hit), 32'(ehit));
    check("rsp_resp", 32'(rsp_resp), 32'(eresp));
    if (!we) check("rsp_rdata", rsp_rdata, erd);
    if (elat != 0) check("rsp_latency", 32'(k), 32'(elat));
    check("mem_ops_left", 32'(exp_ops.size()), 0);
    @(negedge clk);
    check("rsp_pulse", 32'(rsp_valid), 0);
    mptr = (c + 1) % 2;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nacc, exp_g, last;
    int acc_core [64];
    logic [19:0] ra;

    rst = 1'b1; req_valid = 2'b11; req_we = '0; req_addr = '0; req_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 0);
    req_valid = 2'b00; rst = 1'b0;
    @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_hit", 32'(rsp_hit), 0);
    check("rst_rsp_resp", 32'(rsp_resp), 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", mem_wdata, 0);

    // Directed scenarios.
    do_txn(0, 0, 20'h00010, 32'h0, 32'hCAFE0001, 0);  // fill -> E
    mem_ack = 1'b1; mem_rdata = 32'h5555AAAA;           // stray ack is ignored
    @(negedge clk); mem_ack = 1'b0;
    check("stray_ack_mem_req", 32'(mem_req), 0);
    check("stray_ack_rsp", 32'(rsp_valid), 0);
    do_txn(1, 0, 20'h00010, 32'h0, 32'hCAFE0001, 1);  // E->S, fill -> S
    do_txn(1, 0, 20'h00010, 32'h0, 32'h0, 0);          // read hit
    do_txn(0, 1, 20'h00010, 32'h0000DEAD, 32'h0, 0);   // S upgrade
    do_txn(1, 0, 20'h00010, 32'h0, 32'h0, 2);          // peer writeback

    // Both cores request continuously: grants must alternate.
    @(negedge clk);
    req_we = 2'b00; req_addr = {20'h00010, 20'h00010}; req_valid = 2'b11;
    for (int i = 0; i < 64; i++) acc_core[i] = -1;
    nacc = 0; exp_g = mptr; last = mptr;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (rsp_valid != 2'b00 && k >= 2) begin
        check("arb_rsp_core", 32'(rsp_valid), 32'(oh(acc_core[k-2])));
        check("arb_rsp_hit", 32'(rsp_hit), 1);
        check("arb_rsp_rdata", rsp_rdata, mdat[0][0]);
      end
      check("arb_no_mem", 32'(mem_req), 0);
      if (req_ready != 2'b00 && nacc < 4) begin
        check("arb_grant", 32'(req_ready), 32'(oh(exp_g)));
        acc_core[k] = req_ready[1] ? 1 : 0;
        last = exp_g; exp_g = (exp_g + 1) % 2; nacc++;
        if (nacc == 4) begin @(posedge clk); #1; req_valid = 2'b00; end
      end
      @(negedge clk);
    end
    check("arb_accept_count", 32'(nacc), 4);
    mptr = (last + 1) % 2;

    do_txn(0, 1, 20'h00010, 32'hBEEF0002, 32'h0, 0);  // S upgrade -> M
    do_txn(0, 1, 20'h00100, 32'h0BAD0003, 32'h0, 5);  // M victim writeback, slow ack

    // Reset during a fill abandons the transaction.
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[19:0] = 20'h00023;
    #1; n = 0;
    while (!req_ready[0] && n < 50) begin @(negedge clk); #1; n++; end
    check("rstfill_accept", 32'(n < 50), 1);
    @(posedge clk); #1; req_valid[0] = 1'b0;
    n = 0;
    while (!mem_req && n < 20) begin @(negedge clk); n++; end
    check("rstfill_req", 32'(mem_req), 1);
    check("rstfill_we", 32'(mem_we), 0);
    check("rstfill_addr", 32'(mem_addr), 32'h23);
    rst = 1'b1;
    @(negedge clk);
    check("rstfill_mem_req", 32'(mem_req), 0);
    check("rstfill_rsp", 32'(rsp_valid), 0);
    rst = 1'b0;
    repeat (4) begin @(negedge clk); check("rstfill_no_rsp", 32'(rsp_valid), 0); end
    model_reset();
    do_txn(1, 0, 20'h00010, 32'h0, 32'h600DF00D, 0);  // lines cleared: fill -> E

    // Random traffic over a small set of conflicting addresses.
    for (int t = 0; t < 150; t++) begin
      ra = 20'($urandom_range(0, 2) * 16 + $urandom_range(0, 3));
      do_txn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra,
             $urandom, $urandom, int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
